// File: rtl/sprite_rom_arb_if.sv
// Bus bundle between the sprite generators (me, bullet, enemy1), the shared
// synchronous sprite ROM and the sprite_rom_arb arbiter.
// master: the requester/ROM side. slave: the arbiter.
interface sprite_rom_arb_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 13
);
  logic              me_req_i;
  logic [ADDR_W-1:0] me_addr_i;
  logic              bullet_req_i;
  logic [ADDR_W-1:0] bullet_addr_i;
  logic              enemy1_req_i;
  logic [ADDR_W-1:0] enemy1_addr_i;
  logic [2:0]        gnt_o;
  logic              rom_en_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [DATA_W-1:0] rom_data_i;
  logic [2:0]        rd_valid_o;
  logic [DATA_W-1:0] rd_data_o;
  logic              starve_o;

  modport master (
    output me_req_i, me_addr_i, bullet_req_i, bullet_addr_i,
           enemy1_req_i, enemy1_addr_i, rom_data_i,
    input  gnt_o, rom_en_o, rom_addr_o, rd_valid_o, rd_data_o, starve_o
  );

  modport slave (
    input  me_req_i, me_addr_i, bullet_req_i, bullet_addr_i,
           enemy1_req_i, enemy1_addr_i, rom_data_i,
    output gnt_o, rom_en_o, rom_addr_o, rd_valid_o, rd_data_o, starve_o
  );
endinterface

// File: rtl/sprite_rom_arb.sv
// Shared sprite-ROM arbiter (clk_vga domain). Grants one of me/bullet/enemy1
// per cycle, drives the synchronous ROM and returns the word three cycles
// after the request with a one-hot valid strobe. A requester being granted
// this cycle is excluded from the next arbitration, so each grant consumes
// exactly one access.
// Optional feature: define SPRITE_ARB_RR_EN for round-robin arbitration;
// otherwise fixed priority me > enemy1 > bullet (bullet may starve).
module sprite_rom_arb #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 13,
  parameter int MAX_WAIT = 15
) (
  input  logic           clk_vga,
  input  logic           rst,
  sprite_rom_arb_if.slave bus
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
  localparam logic [7:0] WAIT_SAT   = 8'hFF;

  // Bit order everywhere: 0 = me, 1 = bullet, 2 = enemy1.
  logic [2:0]        req;
  logic [2:0]        elig;
  logic [2:0]        gnt_d, gnt_q;
  logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;
  logic [2:0]        pipe_q;       // grant tag for the cycle the ROM is reading
  logic [2:0]        rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [7:0]        wait_cnt_d [3];
  logic [7:0]        wait_cnt_q [3];
  logic              starve_d, starve_q;

  assign req  = {bus.enemy1_req_i, bus.bullet_req_i, bus.me_req_i};
  assign elig = req & ~gnt_q;

`ifdef SPRITE_ARB_RR_EN
  typedef enum logic [1:0] {
    REQ_ME     = 2'd0,
    REQ_BULLET = 2'd1,
    REQ_ENEMY1 = 2'd2
  } req_e;

  req_e ptr_d, ptr_q;

  // Round-robin pick: search starts at the requester after the last winner.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt_d = '0;
    ptr_d = ptr_q;
    case (ptr_q)
      REQ_ME: begin
        if      (elig[1]) gnt_d = 3'b010;
        else if (elig[2]) gnt_d = 3'b100;
        else if (elig[0]) gnt_d = 3'b001;
      end
      REQ_BULLET: begin
        if      (elig[2]) gnt_d = 3'b100;
        else if (elig[0]) gnt_d = 3'b001;
        else if (elig[1]) gnt_d = 3'b010;
      end
      default: begin
        if      (elig[0]) gnt_d = 3'b001;
        else if (elig[1]) gnt_d = 3'b010;
        else if (elig[2]) gnt_d = 3'b100;
      end
    endcase
    if      (gnt_d[0]) ptr_d = REQ_ME;
    else if (gnt_d[1]) ptr_d = REQ_BULLET;
    else if (gnt_d[2]) ptr_d = REQ_ENEMY1;
  end

  // Pointer register; enemy1 after reset so that me wins first.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_vga) begin
    if (rst) ptr_q <= REQ_ENEMY1;
    else     ptr_q <= ptr_d;
  end
`else
  // Fixed priority pick: me > enemy1 > bullet.
  always_comb begin
    gnt_d = '0;
    if      (elig[0]) gnt_d = 3'b001;
    else if (elig[2]) gnt_d = 3'b100;
    else if (elig[1]) gnt_d = 3'b010;
  end
`endif

  // ROM address follows the winner; it holds when nobody is granted.
  always_comb begin
    rom_addr_d = rom_addr_q;
    case (gnt_d)
      3'b001:  rom_addr_d = bus.me_addr_i;
      3'b010:  rom_addr_d = bus.bullet_addr_i;
      3'b100:  rom_addr_d = bus.enemy1_addr_i;
      default: rom_addr_d = rom_addr_q;
    endcase
  end

  // Wait counters and starvation: a counter that would reach MAX_WAIT on the
  // edge its owner is granted is cleared instead, so it never flags.
  always_comb begin
    starve_d = starve_q;
    for (int k = 0; k < 3; k++) begin
      if (!req[k] || gnt_d[k])         wait_cnt_d[k] = '0;
      else if (wait_cnt_q[k] != WAIT_SAT) wait_cnt_d[k] = wait_cnt_q[k] + 8'd1;
      else                             wait_cnt_d[k] = wait_cnt_q[k];
      if (wait_cnt_d[k] >= MAX_WAIT_C) starve_d = 1'b1;
    end
  end

  // Grant register, return pipeline, wait counters and sticky starve flag.
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      gnt_q      <= '0;
      rom_addr_q <= '0;
      pipe_q     <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
      starve_q   <= 1'b0;
      // NOTE: the wait counters are ordinary flops, not a memory, so they are
      // reset explicitly along with the rest of the state.
      for (int k = 0; k < 3; k++) wait_cnt_q[k] <= '0;
    end else begin
      gnt_q      <= gnt_d;
      rom_addr_q <= rom_addr_d;
      pipe_q     <= gnt_q;
      rd_valid_q <= pipe_q;
      if (|pipe_q) rd_data_q <= bus.rom_data_i;
      starve_q   <= starve_d;
      for (int k = 0; k < 3; k++) wait_cnt_q[k] <= wait_cnt_d[k];
    end
  end

  assign bus.gnt_o      = gnt_q;
  assign bus.rom_en_o   = |gnt_q;
  assign bus.rom_addr_o = rom_addr_q;
  assign bus.rd_valid_o = rd_valid_q;
  assign bus.rd_data_o  = rd_data_q;
  assign bus.starve_o   = starve_q;

endmodule

// File: tb/tb_sprite_rom_arb.sv
// Self-checking bench for sprite_rom_arb: a directed vector table, hand
// sequences for contention, back-to-back, reset and idle, then random traffic
// compared every cycle against a transaction-level reference model.
module tb_sprite_rom_arb;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 13;
  localparam int MAX_WAIT = 15;

  logic clk_vga = 1'b0;
  logic rst     = 1'b1;
  always #5 clk_vga = ~clk_vga;

  sprite_rom_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sprite_rom_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_vga(clk_vga),
    .rst    (rst),
    .bus    (bus)
  );

  // ROM contents: an arbitrary but deterministic word per address.
  function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    w = {1'b0, a};
    return (w * 13'd97) ^ 13'h0A5A;
  endfunction

  // Synchronous ROM: word appears the cycle after the enable.
  logic [DATA_W-1:0] rom_q = '0;
  always_ff @(posedge clk_vga) if (bus.rom_en_o) rom_q <= rom_fn(bus.rom_addr_o);
  assign bus.rom_data_i = rom_q;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    int                due;
    int                idx;
    logic [DATA_W-1:0] word;
  } ret_t;

  ret_t              m_q[$];
  int                cyc = 0;
  int                m_gnt = -1;
  int                m_wait[3] = '{0, 0, 0};
  bit                m_starve = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [2:0]        m_valid = '0;
  logic [DATA_W-1:0] m_data = '0;
`ifdef SPRITE_ARB_RR_EN
  int                m_last = 2;
`else
  int                prio_order[3] = '{0, 2, 1};
`endif
  logic [2:0]        cur_req = '0;
  logic [ADDR_W-1:0] cur_addr[3];
  bit                model_on = 1'b0;

  task automatic model_update(input logic r);
    int win;
    int c;
    cyc++;
    if (r) begin
      m_gnt = -1;
      for (int k = 0; k < 3; k++) m_wait[k] = 0;
      m_starve = 1'b0;
      m_addr   = '0;
      m_valid  = '0;
      m_data   = '0;
      m_q.delete();
`ifdef SPRITE_ARB_RR_EN
      m_last = 2;
`endif
      return;
    end
    win = -1;
    for (int i = 0; i < 3; i++) begin
`ifdef SPRITE_ARB_RR_EN
      c = (m_last + 1 + i) % 3;
`else
      c = prio_order[i];
`endif
      if (win < 0 && cur_req[c] && c != m_gnt) win = c;
    end
    for (int k = 0; k < 3; k++) begin
      if (!cur_req[k] || k == win) m_wait[k] = 0;
      else if (m_wait[k] < 255)    m_wait[k] = m_wait[k] + 1;
      if (m_wait[k] >= MAX_WAIT) m_starve = 1'b1;
    end
    m_valid = '0;
    if (m_q.size() > 0 && m_q[0].due == cyc) begin
      m_valid = 3'(1 << m_q[0].idx);
      m_data  = m_q[0].word;
      void'(m_q.pop_front());
    end
    if (win >= 0) begin
      m_addr = cur_addr[win];
`ifdef SPRITE_ARB_RR_EN
      m_last = win;
`endif
      m_q.push_back('{cyc + 2, win, rom_fn(cur_addr[win])});
    end
    m_gnt = win;
  endtask

  task automatic compare_model();
    logic [2:0] exp_gnt;
    exp_gnt = (m_gnt < 0) ? 3'b000 : 3'(1 << m_gnt);
    check("model gnt",      32'(bus.gnt_o),      32'(exp_gnt));
    check("model rom_en",   32'(bus.rom_en_o),   32'(m_gnt >= 0));
    check("model rom_addr", 32'(bus.rom_addr_o), 32'(m_addr));
    check("model rd_valid", 32'(bus.rd_valid_o), 32'(m_valid));
    check("model rd_data",  32'(bus.rd_data_o),  32'(m_data));
    check("model starve",   32'(bus.starve_o),   32'(m_starve));
  endtask

  // One clock: drive inputs, let the edge happen, update model, sample #1 later.
  task automatic step(input logic r, input logic [2:0] rq,
                      input logic [ADDR_W-1:0] a_me, a_bu, a_en);
    rst               = r;
    bus.me_req_i      = rq[0];
    bus.bullet_req_i  = rq[1];
    bus.enemy1_req_i  = rq[2];
    bus.me_addr_i     = a_me;
    bus.bullet_addr_i = a_bu;
    bus.enemy1_addr_i = a_en;
    cur_req     = rq;
    cur_addr[0] = a_me;
    cur_addr[1] = a_bu;
    cur_addr[2] = a_en;
    @(posedge clk_vga);
    model_update(r);
    #1;
    if (model_on) compare_model();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic              r;
    logic [2:0]        req;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        gnt;
    logic              en;
    logic [ADDR_W-1:0] rom_addr;
    logic [2:0]        valid;
    logic [DATA_W-1:0] data;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]        got_v[$];
    logic [DATA_W-1:0] got_d[$];
    logic [2:0]        exp_seq[6];
    logic [2:0]        rq;

    vecs[0] = '{1'b1, 3'b000, 12'h000, 3'b000, 1'b0, 12'h000, 3'b000, 13'h0};
    vecs[1] = '{1'b0, 3'b001, 12'h0A5, 3'b001, 1'b1, 12'h0A5, 3'b000, 13'h0};
    vecs[2] = '{1'b0, 3'b000, 12'h000, 3'b000, 1'b0, 12'h0A5, 3'b000, 13'h0};
    vecs[3] = '{1'b0, 3'b000, 12'h000, 3'b000, 1'b0, 12'h0A5, 3'b001, rom_fn(12'h0A5)};
    vecs[4] = '{1'b0, 3'b010, 12'h03C, 3'b010, 1'b1, 12'h03C, 3'b000, rom_fn(12'h0A5)};
    vecs[5] = '{1'b0, 3'b000, 12'h000, 3'b000, 1'b0, 12'h03C, 3'b000, rom_fn(12'h0A5)};
    vecs[6] = '{1'b0, 3'b000, 12'h000, 3'b000, 1'b0, 12'h03C, 3'b010, rom_fn(12'h03C)};
    vecs[7] = '{1'b0, 3'b100, 12'hFFF, 3'b100, 1'b1, 12'hFFF, 3'b000, rom_fn(12'h03C)};
    vecs[8] = '{1'b0, 3'b000, 12'h000, 3'b000, 1'b0, 12'hFFF, 3'b000, rom_fn(12'h03C)};
    vecs[9] = '{1'b0, 3'b000, 12'h000, 3'b000, 1'b0, 12'hFFF, 3'b100, rom_fn(12'hFFF)};

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].r, vecs[i].req, vecs[i].addr, vecs[i].addr, vecs[i].addr);
      check($sformatf("vec%0d gnt", i),      32'(bus.gnt_o),      32'(vecs[i].gnt));
      check($sformatf("vec%0d rom_en", i),   32'(bus.rom_en_o),   32'(vecs[i].en));
      check($sformatf("vec%0d rom_addr", i), 32'(bus.rom_addr_o), 32'(vecs[i].rom_addr));
      check($sformatf("vec%0d rd_valid", i), 32'(bus.rd_valid_o), 32'(vecs[i].valid));
      check($sformatf("vec%0d rd_data", i),  32'(bus.rd_data_o),  32'(vecs[i].data));
    end

    model_on = 1'b1;

    // Idle: nothing requested for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 3'b000, '0, '0, '0);
      check("idle gnt",      32'(bus.gnt_o),      32'h0);
      check("idle rom_en",   32'(bus.rom_en_o),   32'h0);
      check("idle rd_valid", 32'(bus.rd_valid_o), 32'h0);
    end

    // Three-way contention.
    step(1'b1, 3'b000, '0, '0, '0);
    got_v.delete();
`ifdef SPRITE_ARB_RR_EN
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 3'b111, 12'h100, 12'h200, 12'h300);
      check($sformatf("rr gnt%0d", i), 32'(bus.gnt_o), 32'(exp_seq[i]));
      if (bus.rd_valid_o != 3'b000) got_v.push_back(bus.rd_valid_o);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'b000, '0, '0, '0);
      if (bus.rd_valid_o != 3'b000) got_v.push_back(bus.rd_valid_o);
    end
    check("rr return count", 32'(got_v.size()), 32'd6);
    for (int i = 0; i < 6 && i < got_v.size(); i++)
      check($sformatf("rr return%0d", i), 32'(got_v[i]), 32'(exp_seq[i]));
    check("rr starve", 32'(bus.starve_o), 32'h0);
`else
    exp_seq = '{3'b001, 3'b100, 3'b001, 3'b100, 3'b001, 3'b100};
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 3'b111, 12'h100, 12'h200, 12'h300);
      check($sformatf("fp gnt%0d", i), 32'(bus.gnt_o), 32'(exp_seq[i % 6]));
      check($sformatf("fp starve%0d", i), 32'(bus.starve_o), 32'((i + 1) >= MAX_WAIT));
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'b000, '0, '0, '0);
      check("fp starve sticky", 32'(bus.starve_o), 32'h1);
    end
`endif

    // Back-to-back enemy1 with a moving address: every second cycle granted.
    step(1'b1, 3'b000, '0, '0, '0);
    got_d.delete();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 3'b100, '0, '0, 12'(i));
      check($sformatf("b2b gnt%0d", i), 32'(bus.gnt_o), (i % 2 == 0) ? 32'h4 : 32'h0);
      if (bus.rd_valid_o == 3'b100) got_d.push_back(bus.rd_data_o);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'b000, '0, '0, '0);
      if (bus.rd_valid_o == 3'b100) got_d.push_back(bus.rd_data_o);
    end
    check("b2b return count", 32'(got_d.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_d.size(); i++)
      check($sformatf("b2b word%0d", i), 32'(got_d[i]), 32'(rom_fn(12'(2 * i))));

    // Reset while a me read is in flight: it must never be signalled.
    step(1'b0, 3'b001, 12'h0A5, '0, '0);
    step(1'b0, 3'b000, '0, '0, '0);
    step(1'b1, 3'b000, '0, '0, '0);
    check("rst gnt",      32'(bus.gnt_o),      32'h0);
    check("rst rom_en",   32'(bus.rom_en_o),   32'h0);
    check("rst rom_addr", 32'(bus.rom_addr_o), 32'h0);
    check("rst rd_valid", 32'(bus.rd_valid_o), 32'h0);
    check("rst rd_data",  32'(bus.rd_data_o),  32'h0);
    check("rst starve",   32'(bus.starve_o),   32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'b000, '0, '0, '0);
      check("rst no late valid", 32'(bus.rd_valid_o), 32'h0);
    end

    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      rq = 3'($urandom) | 3'($urandom);
      step(($urandom_range(0, 63) == 0), rq,
           12'($urandom), 12'($urandom), 12'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
